// File: rtl/uart_text_buffer.sv
// 4x16 character store fed by UART bytes; interprets printable/control codes, runs clear and newline-fill sequences.
// Read latency 1 cycle; no backpressure: one pending byte slot, a further byte while it is full is dropped and sets sticky overflow.
module uart_text_buffer #(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] NL_CODE    = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byteReady,
    input  logic [7:0] dataIn,
    input  logic [5:0] charAddress,
    output logic [7:0] charOutput,
    output logic [5:0] cursor,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cursor_q, cursor_d;
    logic [5:0] clr_idx_q, clr_idx_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] pend_dat_q, pend_dat_d;
    logic       ovf_q, ovf_d;
    logic       br_q;
    logic [7:0] char_q;

    logic [7:0] mem [64];
    logic       we;
    logic [5:0] waddr;
    logic [7:0] wdata;
    logic       consume;
    logic       byte_evt;
    logic [1:0] row_nxt;

    assign byte_evt = byteReady & ~br_q;
    assign row_nxt  = cursor_q[5:4] + 2'd1;

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        clr_idx_d = clr_idx_q;
        we        = 1'b0;
        waddr     = cursor_q;
        wdata     = BLANK_CHAR;
        consume   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                we        = 1'b1;
                waddr     = clr_idx_q;
                clr_idx_d = clr_idx_q + 6'd1;
                if (clr_idx_q == 6'd63) begin
                    state_d  = ST_IDLE;
                    cursor_d = 6'd0;
                end
            end
            ST_FILL: begin
                we = 1'b1;
                if (cursor_q[3:0] == 4'hF) begin
                    cursor_d = {row_nxt, 4'h0};
                    state_d  = ST_IDLE;
                end else begin
                    cursor_d = cursor_q + 6'd1;
                end
            end
            ST_IDLE: begin
                if (pend_vld_q) begin
                    consume = 1'b1;
                    if (pend_dat_q == NL_CODE) begin
                        // Newline at the last column needs no fill sequence.
                        if (cursor_q[3:0] == 4'hF) begin
                            we       = 1'b1;
                            cursor_d = {row_nxt, 4'h0};
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else if (pend_dat_q == 8'h0D) begin
                        cursor_d = {cursor_q[5:4], 4'h0};
                    end else if (pend_dat_q == 8'h08) begin
                        if (cursor_q[3:0] != 4'h0) begin
                            we       = 1'b1;
                            waddr    = cursor_q - 6'd1;
                            cursor_d = cursor_q - 6'd1;
                        end
                    end else if (pend_dat_q == 8'h0C) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = 6'd0;
                        cursor_d  = 6'd0;
                    end else if (pend_dat_q >= 8'h20 && pend_dat_q <= 8'h7E) begin
                        we       = 1'b1;
                        wdata    = pend_dat_q;
                        cursor_d = cursor_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = 6'd0;
                cursor_d  = 6'd0;
            end
        endcase
    end

    // A byte arriving in the same cycle the slot is consumed still fits.
    always_comb begin
        pend_vld_d = pend_vld_q & ~consume;
        pend_dat_d = pend_dat_q;
        ovf_d      = ovf_q;
        if (byte_evt) begin
            if (pend_vld_q && !consume) begin
                ovf_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_dat_d = dataIn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            cursor_q   <= 6'd0;
            clr_idx_q  <= 6'd0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= 8'h00;
            ovf_q      <= 1'b0;
            br_q       <= 1'b0;
            char_q     <= BLANK_CHAR;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            clr_idx_q  <= clr_idx_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            ovf_q      <= ovf_d;
            br_q       <= byteReady;
            char_q     <= (state_q == ST_CLEAR) ? BLANK_CHAR : mem[charAddress];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign charOutput = char_q;
    assign cursor     = cursor_q;
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_text_buffer.sv
// Bench for uart_text_buffer: reference text grid model, scoreboard queues drained by a monitor.
module tb_uart_text_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       byteReady = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic [5:0] charAddress = 6'd0;
    logic [7:0] charOutput;
    logic [5:0] cursor;
    logic       busy;
    logic       overflow;

    uart_text_buffer dut (
        .clk(clk), .reset(reset), .byteReady(byteReady), .dataIn(dataIn),
        .charAddress(charAddress), .charOutput(charOutput), .cursor(cursor),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] exp;
    } st_item_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] rdq[$];
    int         rda[$];
    st_item_t   stq[$];
    int         bq[$];
    logic       rd_vld = 1'b0;
    logic       rd_seen = 1'b0;
    logic       st_vld = 1'b0;
    int         bcnt = 0;

    logic [7:0] mem_m[64];
    int         cur_m;
    bit         ovf_m;

    always @(posedge clk) rd_seen <= rd_vld;

    function automatic string kname(input int k);
        case (k)
            1: return "cursor";
            2: return "busy";
            3: return "overflow";
            default: return "charOutput_now";
        endcase
    endfunction

    // Monitor: read-data queue (1-cycle latency), status queue, busy run lengths.
    initial forever begin
        @(negedge clk);
        if (rd_seen) begin
            tests++;
            if (rdq.size() == 0) begin
                fails++;
                $display("FAIL read_unexpected got %h required nothing", charOutput);
            end else begin
                logic [7:0] e;
                int a;
                e = rdq.pop_front();
                a = rda.pop_front();
                if (charOutput !== e) begin
                    fails++;
                    $display("FAIL read addr %0d got %h required %h", a, charOutput, e);
                end
            end
        end
        if (st_vld) begin
            while (stq.size() > 0) begin
                st_item_t it;
                logic [7:0] act;
                it = stq.pop_front();
                case (it.kind)
                    1: act = {2'b00, cursor};
                    2: act = {7'd0, busy};
                    3: act = {7'd0, overflow};
                    default: act = charOutput;
                endcase
                tests++;
                if (act !== it.exp) begin
                    fails++;
                    $display("FAIL %s got %h required %h", kname(it.kind), act, it.exp);
                end
            end
        end
        if (reset) begin
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end else if (bcnt > 0) begin
            tests++;
            if (bq.size() == 0) begin
                fails++;
                $display("FAIL busy_run_unexpected got %0d cycles required none", bcnt);
            end else begin
                int e;
                e = bq.pop_front();
                if (bcnt != e) begin
                    fails++;
                    $display("FAIL busy_run got %0d cycles required %0d", bcnt, e);
                end
            end
            bcnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mem_m[i] = 8'h20;
        cur_m = 0;
    endtask

    // Reference: grid of 4 rows x 16 columns, cursor as a plain integer.
    task automatic model_apply(input logic [7:0] b);
        int row, col;
        row = cur_m / 16;
        col = cur_m % 16;
        if (b == 8'h0A) begin
            for (int c = col; c < 16; c++) mem_m[row * 16 + c] = 8'h20;
            cur_m = ((row + 1) % 4) * 16;
            if (col != 15) bq.push_back(16 - col);
        end else if (b == 8'h0D) begin
            cur_m = row * 16;
        end else if (b == 8'h08) begin
            if (col > 0) begin
                cur_m = cur_m - 1;
                mem_m[cur_m] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_clear();
            bq.push_back(64);
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            mem_m[cur_m] = b;
            cur_m = (cur_m + 1) % 64;
        end
    endtask

    task automatic push_st(input int kind, input logic [7:0] e);
        st_item_t it;
        it.kind = kind;
        it.exp  = e;
        stq.push_back(it);
    endtask

    task automatic chk_status();
        push_st(1, 8'(cur_m));
        push_st(2, 8'h00);
        push_st(3, {7'd0, ovf_m});
        st_vld = 1'b1;
        tick();
        st_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        repeat (3) tick();
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout got busy=1 required busy=0 within 300 cycles");
        end
        repeat (2) tick();
    endtask

    task automatic sweep();
        for (int a = 0; a < 64; a++) begin
            charAddress = 6'(a);
            rdq.push_back(mem_m[a]);
            rda.push_back(a);
            rd_vld = 1'b1;
            tick();
        end
        rd_vld = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        model_apply(b);
        byteReady = 1'b1;
        dataIn    = b;
        repeat (hold) tick();
        byteReady = 1'b0;
        tick();
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push_st(1, 8'h00);
        push_st(2, 8'h01);
        push_st(3, 8'h00);
        push_st(4, 8'h20);
        st_vld = 1'b1;
        tick();
        st_vld = 1'b0;
        tick();
        model_clear();
        ovf_m = 1'b0;
        bq.push_back(64);
        reset = 1'b0;
        wait_idle();
    endtask

    initial begin
        #600000;
        fails++;
        $display("FAIL watchdog got timeout required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int r;
        tick();
        // 1: reset and full clear
        do_reset();
        repeat (10) tick();
        sweep();
        chk_status();

        // 2: long-held byteReady yields exactly one byte each
        send_byte(8'h48, 100);
        send_byte(8'h69, 100);
        chk_status();
        sweep();

        // 3: newline fill from column 5 and from row 3 column 5
        send_byte(8'h61, 1);
        send_byte(8'h62, 2);
        send_byte(8'h63, 1);
        send_byte(8'h0A, 1);
        chk_status();
        for (int i = 0; i < 37; i++) send_byte(8'h30 + 8'(i % 10), 1);
        send_byte(8'h0A, 1);
        chk_status();
        sweep();

        // 4: cursor wrap and backspace at column boundaries
        send_byte(8'h0C, 1);
        for (int i = 0; i < 64; i++) send_byte(8'h41 + 8'(i % 62), 1);
        send_byte(8'h5A, 1);
        chk_status();
        send_byte(8'h08, 1);
        chk_status();
        send_byte(8'h08, 1);
        chk_status();
        sweep();

        // 5: bytes during CLEAR: one held, one dropped; reads forced blank
        model_apply(8'h0C);
        charAddress = 6'd63;
        byteReady = 1'b1;
        dataIn    = 8'h0C;
        tick();
        tick();
        byteReady = 1'b0;
        tick();
        rdq.push_back(8'h20);
        rda.push_back(63);
        rd_vld = 1'b1;
        tick();
        rd_vld = 1'b0;
        byteReady = 1'b1;
        dataIn    = 8'h51;
        tick();
        tick();
        byteReady = 1'b0;
        tick();
        tick();
        byteReady = 1'b1;
        dataIn    = 8'h52;
        tick();
        tick();
        byteReady = 1'b0;
        tick();
        wait_idle();
        model_apply(8'h51);
        ovf_m = 1'b1;
        chk_status();
        sweep();

        // 6: reset during a FILL with a byte pending
        send_byte(8'h61, 1);
        send_byte(8'h62, 1);
        send_byte(8'h63, 1);
        send_byte(8'h0A, 1);
        send_byte(8'h78, 1);
        send_byte(8'h79, 1);
        send_byte(8'h0D, 1);
        chk_status();
        charAddress = 6'd1;
        byteReady = 1'b1;
        dataIn    = 8'h0A;
        tick();
        byteReady = 1'b0;
        tick();
        byteReady = 1'b1;
        dataIn    = 8'h58;
        tick();
        byteReady = 1'b0;
        repeat (4) tick();
        push_st(2, 8'h01);
        push_st(3, 8'h01);
        push_st(4, 8'h61);
        st_vld = 1'b1;
        tick();
        st_vld = 1'b0;
        do_reset();
        chk_status();
        sweep();

        // Random byte stream against the reference grid
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(32, 126));
            else if (r < 70) b = 8'h0A;
            else if (r < 78) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 97) b = 8'($urandom_range(127, 255));
            else             b = 8'h0C;
            send_byte(b, $urandom_range(1, 3));
            if (k % 50 == 49) begin
                chk_status();
                sweep();
            end
        end

        repeat (5) tick();
        tests++;
        if (rdq.size() != 0) begin
            fails++;
            $display("FAIL read_queue_left got %0d required 0", rdq.size());
        end
        tests++;
        if (stq.size() != 0) begin
            fails++;
            $display("FAIL status_queue_left got %0d required 0", stq.size());
        end
        tests++;
        if (bq.size() != 0) begin
            fails++;
            $display("FAIL busy_queue_left got %0d required 0", bq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
